main_fsm: RTL and testbench

Multicycle RISC-V main controller: a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It drives the multiplexer selects and write enables of a shared-ALU, shared-memory datapath. It adds a ready/valid-style memory wait handshake, illegal-opcode trapping, optional LUI support and a retired-instruction counter. It sits between the instruction register's opcode field and the multicycle datapath, alongside the existing ALU decoder, which consumes `aluOp`.

---
 rtl/main_fsm_pkg.sv | 77 +++++++
 rtl/imm_src_deco.sv | 27 ++
 rtl/main_fsm.sv | 187 ++++++++++++++++++
 tb/tb_main_fsm.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : main_fsm_pkg
// Brief    : State, opcode and datapath-select encodings for the multicycle
//            RISC-V controller and its ALU decoder.
// Revision : 1.0
// ============================================================================
package main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    // Opcodes (instr[6:0])
    localparam logic [6:0] c_OP_LW    = 7'b0000011;
    localparam logic [6:0] c_OP_SW    = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;

    // resultSrc
    localparam logic [1:0] c_RES_ALUOUT    = 2'b00;
    localparam logic [1:0] c_RES_DATA      = 2'b01;
    localparam logic [1:0] c_RES_ALURESULT = 2'b10;

    // aluSrcA
    localparam logic [1:0] c_SRCA_PC    = 2'b00;
    localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] c_SRCA_RS1   = 2'b10;
    localparam logic [1:0] c_SRCA_ZERO  = 2'b11;

    // aluSrcB
    localparam logic [1:0] c_SRCB_RS2   = 2'b00;
    localparam logic [1:0] c_SRCB_IMM   = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b10;

    // aluOp, shared with the ALU decoder
    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    // immSrc
    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_S = 3'b001;
    localparam logic [2:0] c_IMM_B = 3'b010;
    localparam logic [2:0] c_IMM_J = 3'b011;
    localparam logic [2:0] c_IMM_U = 3'b100;

    // State entered from DECODE; anything unrecognised traps.
    function automatic state_t decode_target(input logic [6:0] op, input logic lui_en);
        case (op)
            c_OP_LW, c_OP_SW: return S_MEMADR;
            c_OP_RTYPE:       return S_EXECR;
            c_OP_ITYPE:       return S_EXECI;
            c_OP_BEQ:         return S_BEQ;
            c_OP_JAL:         return S_JAL;
            c_OP_LUI:         return lui_en ? S_LUI : S_TRAP;
            default:          return S_TRAP;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_src_deco.sv
`default_nettype none
// ============================================================================
// Module   : imm_src_deco
// Brief    : Combinational opcode to immediate-format select.
// Revision : 1.0
// ============================================================================
module imm_src_deco
    import main_fsm_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] immSrc
);

    always_comb begin
        immSrc = c_IMM_I;
        case (op)
            c_OP_LW, c_OP_ITYPE: immSrc = c_IMM_I;
            c_OP_SW:             immSrc = c_IMM_S;
            c_OP_BEQ:            immSrc = c_IMM_B;
            c_OP_JAL:            immSrc = c_IMM_J;
            c_OP_LUI:            immSrc = c_IMM_U;
            default:             immSrc = c_IMM_I;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/main_fsm.sv
`default_nettype none
// ============================================================================
// Module   : main_fsm
// Brief    : Multicycle RISC-V main controller (Moore FSM) with memory wait
//            handshake, illegal-opcode trap and retired-instruction counter.
// Revision : 1.0
// ============================================================================
module main_fsm
    import main_fsm_pkg::*;
#(
    parameter int ENABLE_LUI = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [6:0]       op,
    input  logic             memReady,
    output logic             memReq,
    output logic             adrSrc,
    output logic             irWrite,
    output logic             pcUpdate,
    output logic             regWrite,
    output logic             memWrite,
    output logic             branch,
    output logic [1:0]       resultSrc,
    output logic [1:0]       aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       aluOp,
    output logic [2:0]       immSrc,
    output logic             illegalOp,
    output logic [CNT_W-1:0] instrCount,
    output logic [3:0]       state
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             w_retire;

    logic       w_memReq, w_irWrite, w_pcUpdate, w_regWrite, w_memWrite, w_branch;
    logic       w_adrSrc;
    logic [1:0] w_resultSrc, w_aluSrcA, w_aluSrcB, w_aluOp;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (memReady) w_next = S_DECODE;
            S_DECODE:   w_next = decode_target(op, ENABLE_LUI != 0);
            S_MEMADR:   w_next = (op == c_OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (memReady) w_next = S_MEMWB;
            S_MEMWRITE: if (memReady) w_next = S_FETCH;
            S_EXECR,
            S_EXECI,
            S_JAL,
            S_LUI:      w_next = S_ALUWB;
            S_MEMWB,
            S_ALUWB,
            S_BEQ:      w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_memReq    = 1'b0;
        w_adrSrc    = 1'b0;
        w_irWrite   = 1'b0;
        w_pcUpdate  = 1'b0;
        w_regWrite  = 1'b0;
        w_memWrite  = 1'b0;
        w_branch    = 1'b0;
        w_resultSrc = c_RES_ALUOUT;
        w_aluSrcA   = c_SRCA_PC;
        w_aluSrcB   = c_SRCB_RS2;
        w_aluOp     = c_ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                // IR load and PC+4 commit only on the cycle memory delivers.
                w_memReq    = 1'b1;
                w_irWrite   = memReady;
                w_pcUpdate  = memReady;
                w_aluSrcB   = c_SRCB_FOUR;
                w_resultSrc = c_RES_ALURESULT;
            end
            S_DECODE: begin
                w_aluSrcA = c_SRCA_OLDPC;
                w_aluSrcB = c_SRCB_IMM;
            end
            S_MEMADR: begin
                w_aluSrcA = c_SRCA_RS1;
                w_aluSrcB = c_SRCB_IMM;
            end
            S_MEMREAD: begin
                w_memReq = 1'b1;
                w_adrSrc = 1'b1;
            end
            S_MEMWB: begin
                w_resultSrc = c_RES_DATA;
                w_regWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                w_memReq   = 1'b1;
                w_adrSrc   = 1'b1;
                w_memWrite = 1'b1;
            end
            S_EXECR: begin
                w_aluSrcA = c_SRCA_RS1;
                w_aluSrcB = c_SRCB_RS2;
                w_aluOp   = c_ALUOP_FUNCT;
            end
            S_EXECI: begin
                w_aluSrcA = c_SRCA_RS1;
                w_aluSrcB = c_SRCB_IMM;
                w_aluOp   = c_ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_resultSrc = c_RES_ALUOUT;
                w_regWrite  = 1'b1;
            end
            S_BEQ: begin
                w_aluSrcA   = c_SRCA_RS1;
                w_aluSrcB   = c_SRCB_RS2;
                w_aluOp     = c_ALUOP_SUB;
                w_resultSrc = c_RES_ALUOUT;
                w_branch    = 1'b1;
            end
            S_JAL: begin
                w_aluSrcA   = c_SRCA_OLDPC;
                w_aluSrcB   = c_SRCB_FOUR;
                w_resultSrc = c_RES_ALUOUT;
                w_pcUpdate  = 1'b1;
            end
            S_LUI: begin
                w_aluSrcA = c_SRCA_ZERO;
                w_aluSrcB = c_SRCB_IMM;
            end
            default: begin
            end
        endcase
    end

    // Enables are gated by resetN so an access in flight is dropped at once.
    assign memReq   = w_memReq   & resetN;
    assign irWrite  = w_irWrite  & resetN;
    assign pcUpdate = w_pcUpdate & resetN;
    assign regWrite = w_regWrite & resetN;
    assign memWrite = w_memWrite & resetN;
    assign branch   = w_branch   & resetN;

    assign adrSrc    = w_adrSrc;
    assign resultSrc = w_resultSrc;
    assign aluSrcA   = w_aluSrcA;
    assign aluSrcB   = w_aluSrcB;
    assign aluOp     = w_aluOp;

    // TRAP is only left through reset, so the state itself is the sticky flag.
    assign illegalOp = (r_state == S_TRAP);
    assign state     = r_state;

    // An instruction retires on any entry into FETCH from another state.
    assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign instrCount = r_count;

    imm_src_deco u_imm_src_deco (
        .op     (op),
        .immSrc (immSrc)
    );

endmodule
`default_nettype wire

// File: tb/tb_main_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_fsm
// Brief    : Directed self-checking bench for main_fsm (two configurations).
// Revision : 1.0
// ============================================================================
module tb_main_fsm;
    import main_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       resetN;
    logic [6:0] op;
    logic       memReady;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // DUT a: ENABLE_LUI=1, CNT_W=32
    logic a_memReq, a_adrSrc, a_irWrite, a_pcUpdate, a_regWrite, a_memWrite, a_branch;
    logic [1:0] a_resultSrc, a_aluSrcA, a_aluSrcB, a_aluOp;
    logic [2:0] a_immSrc;
    logic a_illegalOp;
    logic [31:0] a_instrCount;
    logic [3:0] a_state;

    // DUT b: ENABLE_LUI=0, CNT_W=2
    logic b_memReq, b_adrSrc, b_irWrite, b_pcUpdate, b_regWrite, b_memWrite, b_branch;
    logic [1:0] b_resultSrc, b_aluSrcA, b_aluSrcB, b_aluOp;
    logic [2:0] b_immSrc;
    logic b_illegalOp;
    logic [1:0] b_instrCount;
    logic [3:0] b_state;

    logic [6:0] a_en, b_en;
    logic [7:0] a_sel;
    assign a_en  = {a_memReq, a_adrSrc, a_irWrite, a_pcUpdate, a_regWrite, a_memWrite, a_branch};
    assign b_en  = {b_memReq, b_adrSrc, b_irWrite, b_pcUpdate, b_regWrite, b_memWrite, b_branch};
    assign a_sel = {a_resultSrc, a_aluSrcA, a_aluSrcB, a_aluOp};

    main_fsm #(.ENABLE_LUI(1), .CNT_W(32)) dut_a (
        .clk(clk), .resetN(resetN), .op(op), .memReady(memReady),
        .memReq(a_memReq), .adrSrc(a_adrSrc), .irWrite(a_irWrite), .pcUpdate(a_pcUpdate),
        .regWrite(a_regWrite), .memWrite(a_memWrite), .branch(a_branch),
        .resultSrc(a_resultSrc), .aluSrcA(a_aluSrcA), .aluSrcB(a_aluSrcB), .aluOp(a_aluOp),
        .immSrc(a_immSrc), .illegalOp(a_illegalOp), .instrCount(a_instrCount), .state(a_state)
    );

    main_fsm #(.ENABLE_LUI(0), .CNT_W(2)) dut_b (
        .clk(clk), .resetN(resetN), .op(op), .memReady(memReady),
        .memReq(b_memReq), .adrSrc(b_adrSrc), .irWrite(b_irWrite), .pcUpdate(b_pcUpdate),
        .regWrite(b_regWrite), .memWrite(b_memWrite), .branch(b_branch),
        .resultSrc(b_resultSrc), .aluSrcA(b_aluSrcA), .aluSrcB(b_aluSrcB), .aluOp(b_aluOp),
        .immSrc(b_immSrc), .illegalOp(b_illegalOp), .instrCount(b_instrCount), .state(b_state)
    );

    // Reset then release with memReady low so the following negedge is a FETCH cycle.
    task automatic do_reset();
        @(negedge clk);
        resetN   = 1'b0;
        memReady = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b1; memReady = 1'b1; op = c_OP_LW;
        #2 resetN = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (a_state !== S_FETCH) begin errors++; $display("FAIL reset_state got %0h expected %0h", a_state, S_FETCH); end
        checks++; if (a_instrCount !== 32'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", a_instrCount); end
        checks++; if (a_illegalOp !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b expected 0", a_illegalOp); end
        checks++; if (a_en !== 7'b0) begin errors++; $display("FAIL reset_enables got %b expected 0000000", a_en); end
        @(negedge clk);
        memReady = 1'b0;
        resetN   = 1'b1;
        #1;
        checks++; if (a_en !== 7'b1000000) begin errors++; $display("FAIL release_enables got %b expected 1000000", a_en); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lw();
        logic [3:0] st [5] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
        logic [6:0] en [5] = '{7'b1011000, 7'b0, 7'b0, 7'b1100000, 7'b0000100};
        logic [7:0] sl [5] = '{8'b10001000, 8'b00010100, 8'b00100100, 8'b0, 8'b01000000};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            memReady = 1'b1; op = c_OP_LW;
            #1;
            checks++; if (a_state !== st[i]) begin errors++; $display("FAIL lw_state[%0d] got %0h expected %0h", i, a_state, st[i]); end
            checks++; if (a_en !== en[i]) begin errors++; $display("FAIL lw_en[%0d] got %b expected %b", i, a_en, en[i]); end
            checks++; if (a_sel !== sl[i]) begin errors++; $display("FAIL lw_sel[%0d] got %b expected %b", i, a_sel, sl[i]); end
            checks++; if (a_immSrc !== 3'b000) begin errors++; $display("FAIL lw_imm[%0d] got %b expected 000", i, a_immSrc); end
        end
        @(posedge clk);
        #1;
        checks++; if (a_state !== S_FETCH) begin errors++; $display("FAIL lw_done_state got %0h expected %0h", a_state, S_FETCH); end
        checks++; if (a_instrCount !== 32'd1) begin errors++; $display("FAIL lw_count got %0d expected 1", a_instrCount); end
    endtask

    task automatic test_fetch_wait();
        logic       rdy [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] st  [7] = '{S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_EXECI, S_ALUWB};
        logic [6:0] en  [7] = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1011000, 7'b0, 7'b0, 7'b0000100};
        logic [7:0] sl  [7] = '{8'b10001000, 8'b10001000, 8'b10001000, 8'b10001000,
                                8'b00010100, 8'b00100110, 8'b0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            memReady = rdy[i]; op = c_OP_ITYPE;
            #1;
            checks++; if (a_state !== st[i]) begin errors++; $display("FAIL fw_state[%0d] got %0h expected %0h", i, a_state, st[i]); end
            checks++; if (a_en !== en[i]) begin errors++; $display("FAIL fw_en[%0d] got %b expected %b", i, a_en, en[i]); end
            checks++; if (a_sel !== sl[i]) begin errors++; $display("FAIL fw_sel[%0d] got %b expected %b", i, a_sel, sl[i]); end
        end
        @(posedge clk);
        #1;
        checks++; if (a_instrCount !== 32'd2) begin errors++; $display("FAIL fw_count got %0d expected 2", a_instrCount); end
    endtask

    task automatic test_sw_wait();
        logic       rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] st  [6] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_MEMWRITE, S_MEMWRITE};
        logic [6:0] en  [6] = '{7'b1011000, 7'b0, 7'b0, 7'b1100010, 7'b1100010, 7'b1100010};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            memReady = rdy[i]; op = c_OP_SW;
            #1;
            checks++; if (a_state !== st[i]) begin errors++; $display("FAIL sw_state[%0d] got %0h expected %0h", i, a_state, st[i]); end
            checks++; if (a_en !== en[i]) begin errors++; $display("FAIL sw_en[%0d] got %b expected %b", i, a_en, en[i]); end
            if (i == 1) begin
                checks++; if (a_immSrc !== 3'b001) begin errors++; $display("FAIL sw_imm got %b expected 001", a_immSrc); end
            end
            if (i == 4) begin
                checks++; if (a_instrCount !== 32'd2) begin errors++; $display("FAIL sw_wait_count got %0d expected 2", a_instrCount); end
            end
        end
        @(posedge clk);
        #1;
        checks++; if (a_state !== S_FETCH) begin errors++; $display("FAIL sw_done_state got %0h expected %0h", a_state, S_FETCH); end
        checks++; if (a_instrCount !== 32'd3) begin errors++; $display("FAIL sw_count got %0d expected 3", a_instrCount); end
    endtask

    task automatic test_beq_jal_addi();
        logic [6:0] ops [11] = '{c_OP_BEQ, c_OP_BEQ, c_OP_BEQ, c_OP_JAL, c_OP_JAL, c_OP_JAL, c_OP_JAL,
                                 c_OP_ITYPE, c_OP_ITYPE, c_OP_ITYPE, c_OP_ITYPE};
        logic [3:0] st  [11] = '{S_FETCH, S_DECODE, S_BEQ, S_FETCH, S_DECODE, S_JAL, S_ALUWB,
                                 S_FETCH, S_DECODE, S_EXECI, S_ALUWB};
        logic [6:0] en  [11] = '{7'b1011000, 7'b0, 7'b0000001, 7'b1011000, 7'b0, 7'b0001000, 7'b0000100,
                                 7'b1011000, 7'b0, 7'b0, 7'b0000100};
        logic [7:0] sl  [11] = '{8'b10001000, 8'b00010100, 8'b00100001, 8'b10001000, 8'b00010100,
                                 8'b00011000, 8'b0, 8'b10001000, 8'b00010100, 8'b00100110, 8'b0};
        logic [2:0] im  [11] = '{3'b010, 3'b010, 3'b010, 3'b011, 3'b011, 3'b011, 3'b011,
                                 3'b000, 3'b000, 3'b000, 3'b000};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            memReady = 1'b1; op = ops[i];
            #1;
            checks++; if (a_state !== st[i]) begin errors++; $display("FAIL bja_state[%0d] got %0h expected %0h", i, a_state, st[i]); end
            checks++; if (a_en !== en[i]) begin errors++; $display("FAIL bja_en[%0d] got %b expected %b", i, a_en, en[i]); end
            checks++; if (a_sel !== sl[i]) begin errors++; $display("FAIL bja_sel[%0d] got %b expected %b", i, a_sel, sl[i]); end
            checks++; if (a_immSrc !== im[i]) begin errors++; $display("FAIL bja_imm[%0d] got %b expected %b", i, a_immSrc, im[i]); end
            if (i == 3) begin
                checks++; if (a_instrCount !== 32'd4) begin errors++; $display("FAIL beq_count got %0d expected 4", a_instrCount); end
            end
        end
        @(posedge clk);
        #1;
        checks++; if (a_instrCount !== 32'd6) begin errors++; $display("FAIL bja_count got %0d expected 6", a_instrCount); end
    endtask

    task automatic test_lui();
        logic [3:0] st [4] = '{S_FETCH, S_DECODE, S_LUI, S_ALUWB};
        logic [6:0] en [4] = '{7'b1011000, 7'b0, 7'b0, 7'b0000100};
        logic [7:0] sl [4] = '{8'b10001000, 8'b00010100, 8'b00110100, 8'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            memReady = 1'b1; op = c_OP_LUI;
            #1;
            checks++; if (a_state !== st[i]) begin errors++; $display("FAIL lui_state[%0d] got %0h expected %0h", i, a_state, st[i]); end
            checks++; if (a_en !== en[i]) begin errors++; $display("FAIL lui_en[%0d] got %b expected %b", i, a_en, en[i]); end
            checks++; if (a_sel !== sl[i]) begin errors++; $display("FAIL lui_sel[%0d] got %b expected %b", i, a_sel, sl[i]); end
        end
        checks++; if (a_immSrc !== 3'b100) begin errors++; $display("FAIL lui_imm got %b expected 100", a_immSrc); end
        @(posedge clk);
        #1;
        checks++; if (a_instrCount !== 32'd7) begin errors++; $display("FAIL lui_count got %0d expected 7", a_instrCount); end
    endtask

    task automatic test_trap();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            memReady = 1'b1; op = 7'b1111111;
            #1;
            if (i >= 2) begin
                checks++; if (a_state !== S_TRAP) begin errors++; $display("FAIL trap_state[%0d] got %0h expected %0h", i, a_state, S_TRAP); end
                checks++; if (a_illegalOp !== 1'b1) begin errors++; $display("FAIL trap_flag[%0d] got %b expected 1", i, a_illegalOp); end
                checks++; if (a_en !== 7'b0) begin errors++; $display("FAIL trap_en[%0d] got %b expected 0000000", i, a_en); end
                checks++; if (a_instrCount !== 32'd0) begin errors++; $display("FAIL trap_count[%0d] got %0d expected 0", i, a_instrCount); end
            end
        end
        @(negedge clk);
        resetN = 1'b0;
        #1;
        checks++; if (a_illegalOp !== 1'b0) begin errors++; $display("FAIL trap_clear got %b expected 0", a_illegalOp); end
        checks++; if (a_state !== S_FETCH) begin errors++; $display("FAIL trap_clear_state got %0h expected %0h", a_state, S_FETCH); end
        do_reset();
        // LUI with ENABLE_LUI=0 must trap on dut_b.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            memReady = 1'b1; op = c_OP_LUI;
            #1;
            if (i >= 2) begin
                checks++; if (b_state !== S_TRAP) begin errors++; $display("FAIL nolui_state[%0d] got %0h expected %0h", i, b_state, S_TRAP); end
                checks++; if (b_illegalOp !== 1'b1) begin errors++; $display("FAIL nolui_flag[%0d] got %b expected 1", i, b_illegalOp); end
                checks++; if (b_en !== 7'b0) begin errors++; $display("FAIL nolui_en[%0d] got %b expected 0000000", i, b_en); end
                checks++; if (b_instrCount !== 2'd0) begin errors++; $display("FAIL nolui_count[%0d] got %0d expected 0", i, b_instrCount); end
            end
        end
        do_reset();
        checks++; if (b_illegalOp !== 1'b0) begin errors++; $display("FAIL nolui_clear got %b expected 0", b_illegalOp); end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [3:0] st [4] = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB};
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                memReady = 1'b1; op = c_OP_RTYPE;
                #1;
                checks++; if (b_state !== st[i]) begin errors++; $display("FAIL wrap_state[%0d][%0d] got %0h expected %0h", k, i, b_state, st[i]); end
                if (k == 0 && i == 2) begin
                    checks++; if (a_sel !== 8'b00100010) begin errors++; $display("FAIL execr_sel got %b expected 00100010", a_sel); end
                end
            end
            @(posedge clk);
            #1;
            checks++; if (b_instrCount !== exp_cnt[k]) begin errors++; $display("FAIL wrap_count[%0d] got %0d expected %0d", k, b_instrCount, exp_cnt[k]); end
        end
    endtask

    task automatic test_reset_midaccess();
        logic rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            memReady = rdy[i]; op = c_OP_LW;
            #1;
        end
        checks++; if (a_en !== 7'b1100000) begin errors++; $display("FAIL mid_memread_en got %b expected 1100000", a_en); end
        #1 resetN = 1'b0;
        #1;
        checks++; if (a_en !== 7'b0) begin errors++; $display("FAIL mid_reset_en got %b expected 0000000", a_en); end
        checks++; if (a_instrCount !== 32'd0) begin errors++; $display("FAIL mid_reset_count got %0d expected 0", a_instrCount); end
        @(negedge clk);
        resetN = 1'b1;
        memReady = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (a_state !== S_FETCH) begin errors++; $display("FAIL mid_release_state got %0h expected %0h", a_state, S_FETCH); end
        checks++; if (a_instrCount !== 32'd0) begin errors++; $display("FAIL mid_release_count got %0d expected 0", a_instrCount); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_fetch_wait();
        test_sw_wait();
        test_beq_jal_addi();
        test_lui();
        test_trap();
        test_wrap();
        test_reset_midaccess();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
